// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Ports: Sys_* clock/reset/enable, DPRF_* dispatch read+rename, RFDP_* operand
// results (combinational), RoBRF_* commit write and flush (pre_judge low).
module register_file #(
    parameter int                      REG_WIDTH    = 5,
    parameter int                      EX_REG_WIDTH = 6,
    parameter logic [EX_REG_WIDTH-1:0] NON_REG      = 6'b100000,
    parameter int                      RoB_WIDTH    = 8,
    parameter int                      EX_RoB_WIDTH = 9,
    parameter logic [EX_RoB_WIDTH-1:0] NON_DEP      = 9'b100000000
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
    input  logic                    DPRF_en,
    input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
    input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
    output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
    output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
    output logic [31:0]             RFDP_Vj,
    output logic [31:0]             RFDP_Vk,
    input  logic                    RoBRF_pre_judge,
    input  logic                    RoBRF_en,
    input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
    input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
    input  logic [31:0]             RoBRF_value
);

    localparam int NREG = 1 << REG_WIDTH;

    logic [31:0]             value_q [NREG];
    logic [31:0]             value_d [NREG];
    logic [EX_RoB_WIDTH-1:0] tag_q   [NREG];
    logic [EX_RoB_WIDTH-1:0] tag_d   [NREG];

    logic                    cm_wr;
    logic                    dp_wr;
    logic [REG_WIDTH-1:0]    cm_rd;
    logic [REG_WIDTH-1:0]    dp_rd;
    logic [EX_RoB_WIDTH-1:0] cm_tag;
    logic [EX_RoB_WIDTH-1:0] dp_tag;

    // A register operand has the "no register" flag clear; x0 is never
    // written or renamed so it stays 0 / NON_DEP from reset.
    function automatic logic is_arch(input logic [EX_REG_WIDTH-1:0] r);
        return ((r & NON_REG) == '0) && (r[REG_WIDTH-1:0] != '0);
    endfunction

    assign cm_rd  = RoBRF_rd[REG_WIDTH-1:0];
    assign dp_rd  = DPRF_rd[REG_WIDTH-1:0];
    assign cm_tag = {1'b0, RoBRF_RoB_index};
    assign dp_tag = {1'b0, DPRF_RoB_index};
    assign cm_wr  = RoBRF_en && is_arch(RoBRF_rd);
    assign dp_wr  = DPRF_en && is_arch(DPRF_rd);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (!RoBRF_pre_judge) begin
            // Flush: every producer is squashed, but the committing
            // instruction is older than the branch so its value stands.
            for (int i = 0; i < NREG; i++) begin
                tag_d[i] = NON_DEP;
            end
            if (cm_wr) begin
                value_d[cm_rd] = RoBRF_value;
            end
        end else if (Sys_rdy) begin
            if (cm_wr) begin
                value_d[cm_rd] = RoBRF_value;
                // Only the latest renamer may release the tag.
                if (tag_q[cm_rd] == cm_tag) begin
                    tag_d[cm_rd] = NON_DEP;
                end
            end
            // Rename is applied last so it wins over a same-cycle release.
            if (dp_wr) begin
                tag_d[dp_rd] = dp_tag;
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= NON_DEP;
            end
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // Operand read with commit bypass of the value being written this cycle.
    always_comb begin
        RFDP_Qj = NON_DEP;
        RFDP_Vj = '0;
        if (is_arch(DPRF_rs1)) begin
            if (RoBRF_en && RoBRF_rd == DPRF_rs1
                && tag_q[DPRF_rs1[REG_WIDTH-1:0]] == cm_tag) begin
                RFDP_Vj = RoBRF_value;
            end else begin
                RFDP_Qj = tag_q[DPRF_rs1[REG_WIDTH-1:0]];
                RFDP_Vj = value_q[DPRF_rs1[REG_WIDTH-1:0]];
            end
        end
    end

    always_comb begin
        RFDP_Qk = NON_DEP;
        RFDP_Vk = '0;
        if (is_arch(DPRF_rs2)) begin
            if (RoBRF_en && RoBRF_rd == DPRF_rs2
                && tag_q[DPRF_rs2[REG_WIDTH-1:0]] == cm_tag) begin
                RFDP_Vk = RoBRF_value;
            end else begin
                RFDP_Qk = tag_q[DPRF_rs2[REG_WIDTH-1:0]];
                RFDP_Vk = value_q[DPRF_rs2[REG_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the dispatcher.
- The dispatcher reads source operands (value or producing RoB tag) and renames destinations at issue.
- The reorder buffer writes committed results and signals misprediction flushes, which clear all rename tags.

Parameters:
REG_WIDTH, 5, architectural register index width (32 registers)
EX_REG_WIDTH, 6, register index plus "no register" flag bit
NON_REG, 6'b100000, encoding for "no register operand / no destination"
RoB_WIDTH, 8, RoB index width
EX_RoB_WIDTH, 9, RoB index plus "no dependency" flag bit
NON_DEP, 9'b100000000, tag value meaning "value is architectural, no pending producer"

Ports:
Sys_clk  input  1  clock; all state updates on posedge
Sys_rst  input  1  synchronous reset, active-high
Sys_rdy  input  1  global enable; state holds when low
DPRF_rs1  input  6  source 1 register (NON_REG if unused)
DPRF_rs2  input  6  source 2 register (NON_REG if unused)
DPRF_en  input  1  rename destination this cycle
DPRF_rd  input  6  destination register (NON_REG if none)
DPRF_RoB_index  input  8  RoB entry allocated to the dispatching instruction
RFDP_Qj  output  9  pending producer tag for rs1, NON_DEP if ready
RFDP_Qk  output  9  pending producer tag for rs2, NON_DEP if ready
RFDP_Vj  output  32  rs1 value (valid when RFDP_Qj == NON_DEP)
RFDP_Vk  output  32  rs2 value (valid when RFDP_Qk == NON_DEP)
RoBRF_pre_judge  input  1  0 = misprediction flush this cycle
RoBRF_en  input  1  commit strobe
RoBRF_RoB_index  input  8  RoB index of committing instruction
RoBRF_rd  input  6  committing destination (NON_REG if none)
RoBRF_value  input  32  committed value

Behaviour:
- Storage: value[0..31] (32 b each) and tag[0..31] (9 b each).
- Reset (Sys_rst high at posedge, highest priority): all values = 0, all tags = NON_DEP. Outputs are combinational, so after reset any query returns Q = NON_DEP and V = 0.
- Read path (combinational, zero latency), per source rs (same rules for rs2 → Qk/Vk):
  - rs == NON_REG or rs == 0 → Q = NON_DEP, V = 0.
  - Commit bypass: RoBRF_en && RoBRF_rd == rs && tag[rs] == {1'b0, RoBRF_RoB_index} → Q = NON_DEP, V = RoBRF_value.
  - Otherwise Q = tag[rs], V = value[rs].
  - Same-cycle dispatch rename is NOT visible to reads, so "add x1,x1,x2" sees the old tag of x1.
- Flush (Sys_rst low, RoBRF_pre_judge low, applies regardless of Sys_rdy):
  - All tags become NON_DEP.
  - A same-cycle valid commit still writes its value.
  - The DPRF_en rename is ignored.
- Normal update (Sys_rst low, RoBRF_pre_judge high, Sys_rdy high):
  - Commit: if RoBRF_en and RoBRF_rd is neither NON_REG nor 0, then value[rd] <= RoBRF_value.
  - Tag clear on commit: tag[rd] <= NON_DEP only if tag[rd] == RoBRF_RoB_index. A stale commit (newer rename present) updates the value but keeps the tag.
  - Dispatch: if DPRF_en and DPRF_rd is neither NON_REG nor 0, then tag[DPRF_rd] <= DPRF_RoB_index.
  - Dispatch and commit to the same register in the same cycle: the dispatch tag wins, and the value is still written.
- Sys_rdy low (no reset, no flush): no state change; reads remain live.
- Register x0: value is constant 0 and tag is constant NON_DEP; writes and renames to x0 are dropped.
- No backpressure outputs; the block accepts one commit and one rename every cycle.

Test Plan:
1. Assert Sys_rst one cycle, then query rs1=5, rs2=31 → Qj=Qk=0x100, Vj=Vk=0.
2. Dispatch rd=5, idx=3; next cycle query rs1=5 → Qj=3. Commit rd=5 idx=3 value=0xDEADBEEF with query rs1=5 in the same cycle → Qj=0x100, Vj=0xDEADBEEF (bypass); following cycle, same result from storage.
3. Dispatch rd=5 idx=3, then rd=5 idx=7; commit rd=5 idx=3 value=0x11 → value[5]=0x11, Qj for rs1=5 stays 7 (no bypass).
4. With tag[5]=3, commit rd=5 idx=3 value=0x22 while dispatching rd=5 idx=9 → next cycle Qj=9, value[5]=0x22; also check that the same-cycle read of rs1=5 returned Qj=0x100, Vj=0x22.
5. Dispatch rd=0 idx=4 and commit rd=0 value=0x55 → query rs1=0: Qj=0x100, Vj=0. Same cycle with NON_REG rd → no change anywhere.
6. Tags on x1..x3 = 1,2,3; hold Sys_rdy low for 3 cycles with commit/dispatch strobes → state unchanged. Then pulse RoBRF_pre_judge=0 with DPRF_en rd=4 idx=8 → all Q = 0x100, values retained, x4 not renamed.
